dht11_sensor_emu: RTL and testbench

//  Responder end of the DHT11 single-wire protocol: emulates the sensor.
//  - Detects the host start pulse and answers with the 80us/80us response, then 40 data bits (MSB first):
//    {hum_int, hum_dec, temp_int, temp_dec, checksum}, then releases the bus.
//  - Used for on-board loopback and bench bring-up of the DHT11 host logic.
//  - Bus is open-drain: the block drives 0 or 'z' only; never drives 1.

---
 rtl/dht11_defs.sv | 48 ++++
 rtl/dht11_sensor_emu_if.sv | 22 ++
 rtl/dht11_bit_timer.sv | 36 +++
 rtl/dht11_sensor_emu.sv | 187 ++++++++++++++++++
 tb/tb_dht11_sensor_emu.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dht11_defs.sv
`timescale 1ns/1ps
// Shared DHT11 definitions: state encodings, default timing (50 MHz clock),
// frame width and small helpers. The host-side logic imports the same package.
package dht11_defs;

    localparam int FRAME_W   = 40;
    localparam int BIT_IDX_W = $clog2(FRAME_W);

    // Default timing in clock cycles at 50 MHz
    localparam int DEF_START_MIN = 50000;  // 1 ms host start pulse
    localparam int DEF_T_TURN    = 1500;   // 30 us turnaround
    localparam int DEF_T_RESP_LO = 4000;   // 80 us
    localparam int DEF_T_RESP_HI = 4000;   // 80 us
    localparam int DEF_T_BIT_LO  = 2500;   // 50 us
    localparam int DEF_T_BIT0_HI = 1300;   // 26 us
    localparam int DEF_T_BIT1_HI = 3500;   // 70 us
    localparam int DEF_CNT_W     = 17;

    typedef enum logic [3:0] {
        ST_ARM,
        ST_IDLE,
        ST_HOST_LO,
        ST_TURN,
        ST_RESP_LO,
        ST_RESP_HI,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_END_LO
    } dht11_state_t;

    // Checksum is the plain 8-bit wrapping sum of the four data bytes.
    function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction

    // States in which the emulator pulls the bus low.
    function automatic logic is_drive_state(input dht11_state_t s);
        return (s == ST_RESP_LO) || (s == ST_BIT_LO) || (s == ST_END_LO);
    endfunction

    // States belonging to an accepted frame (turnaround through end-of-frame low).
    function automatic logic is_busy_state(input dht11_state_t s);
        return (s == ST_TURN) || (s == ST_RESP_LO) || (s == ST_RESP_HI) ||
               (s == ST_BIT_LO) || (s == ST_BIT_HI) || (s == ST_END_LO);
    endfunction

endpackage

// File: rtl/dht11_sensor_emu_if.sv
`timescale 1ns/1ps
// Payload bytes, error-injection control and status of the DHT11 sensor emulator.
// The master side supplies the measurement bytes; the slave side is the emulator.
interface dht11_sensor_emu_if;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       bad_sum;
    logic       busy;
    logic       frame_done;

    modport master (
        output hum_int, hum_dec, temp_int, temp_dec, bad_sum,
        input  busy, frame_done
    );

    modport slave (
        input  hum_int, hum_dec, temp_int, temp_dec, bad_sum,
        output busy, frame_done
    );
endinterface

// File: rtl/dht11_bit_timer.sv
`timescale 1ns/1ps
// Loadable down-counter used to time every protocol phase. Loading P-1 on the
// cycle a phase is entered makes done_o rise in the phase's P-th cycle.
module dht11_bit_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload wins, otherwise count down and rest at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/dht11_sensor_emu.sv
`timescale 1ns/1ps
// DHT11 sensor emulator: detects the host start pulse, answers with the
// response pulse pair and 40 data bits, then releases the open-drain bus.
module dht11_sensor_emu
    import dht11_defs::*;
#(
    parameter int START_MIN = DEF_START_MIN,
    parameter int T_TURN    = DEF_T_TURN,
    parameter int T_RESP_LO = DEF_T_RESP_LO,
    parameter int T_RESP_HI = DEF_T_RESP_HI,
    parameter int T_BIT_LO  = DEF_T_BIT_LO,
    parameter int T_BIT0_HI = DEF_T_BIT0_HI,
    parameter int T_BIT1_HI = DEF_T_BIT1_HI,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               data,
    dht11_sensor_emu_if.slave bus
);
    dht11_state_t         state_q;
    dht11_state_t         state_d;
    logic                 sync1_q;
    logic                 ds_q;
    logic [CNT_W-1:0]     hcnt_q;
    logic [CNT_W-1:0]     hcnt_d;
    logic [FRAME_W-1:0]   shreg_q;
    logic [BIT_IDX_W-1:0] bit_q;
    logic                 drive_q;
    logic                 busy_q;
    logic                 frame_done_q;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_done;
    logic                 accept;
    logic                 bit_init;
    logic                 bit_dec;

    dht11_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .done_o    (tmr_done)
    );

    // Two-flop synchronizer on the bus; idles high like a released bus
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            ds_q    <= 1'b1;
        end else begin
            sync1_q <= data;
            ds_q    <= sync1_q;
        end
    end

    // Protocol sequencing: next state, phase timer loads and frame bookkeeping
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        accept   = 1'b0;
        bit_init = 1'b0;
        bit_dec  = 1'b0;
        unique case (state_q)
            ST_ARM: begin
                // Our own end-of-frame low echoes through the synchronizer;
                // wait for a clean high before watching for a new start.
                if (ds_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                hcnt_d = '0;
                if (!ds_q) state_d = ST_HOST_LO;
            end
            ST_HOST_LO: begin
                if (!ds_q) begin
                    if (hcnt_q != '1) hcnt_d = hcnt_q + 1'b1;
                end else if (hcnt_q >= CNT_W'(START_MIN)) begin
                    state_d  = ST_TURN;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_TURN - 1);
                    accept   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (tmr_done) begin
                    state_d  = ST_RESP_LO;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_RESP_LO - 1);
                end
            end
            ST_RESP_LO: begin
                if (tmr_done) begin
                    state_d  = ST_RESP_HI;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_RESP_HI - 1);
                end
            end
            ST_RESP_HI: begin
                if (tmr_done) begin
                    state_d  = ST_BIT_LO;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_BIT_LO - 1);
                    bit_init = 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (tmr_done) begin
                    state_d  = ST_BIT_HI;
                    tmr_load = 1'b1;
                    tmr_val  = shreg_q[bit_q] ? CNT_W'(T_BIT1_HI - 1) : CNT_W'(T_BIT0_HI - 1);
                end
            end
            ST_BIT_HI: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_BIT_LO - 1);
                    if (bit_q == '0) begin
                        state_d = ST_END_LO;
                    end else begin
                        state_d = ST_BIT_LO;
                        bit_dec = 1'b1;
                    end
                end
            end
            ST_END_LO: begin
                if (tmr_done) state_d = ST_ARM;
            end
            default: state_d = ST_ARM;
        endcase
    end

    // State and host-pulse width registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARM;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Freeze payload and checksum at start accept; walk the bit index MSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            bit_q   <= '0;
        end else begin
            if (accept) begin
                shreg_q <= {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec,
                            frame_checksum(bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec)
                            ^ {7'd0, bus.bad_sum}};
            end
            if (bit_init) begin
                bit_q <= BIT_IDX_W'(FRAME_W - 1);
            end else if (bit_dec) begin
                bit_q <= bit_q - 1'b1;
            end
        end
    end

    // Registered bus drive and status; frame_done fires on the cycle the
    // end-of-frame low is let go (first cycle of ARM with drive still set)
    always_ff @(posedge clk) begin
        if (rst) begin
            drive_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            drive_q      <= is_drive_state(state_q);
            busy_q       <= is_busy_state(state_d);
            frame_done_q <= (state_q == ST_ARM) && drive_q;
        end
    end

    assign data           = drive_q ? 1'b0 : 1'bz;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dht11_sensor_emu.sv
`timescale 1ns/1ps
// Bench for dht11_sensor_emu with scaled timing. A frame model turns the
// payload into the expected bus/busy/frame_done timeline; one process compares
// every sampled cycle, and a receiver decoder pins the frames to literals.
module tb_dht11_sensor_emu;
    localparam int P_START = 20;
    localparam int P_TURN  = 3;
    localparam int P_RLO   = 8;
    localparam int P_RHI   = 8;
    localparam int P_BLO   = 5;
    localparam int P_B0    = 3;
    localparam int P_B1    = 7;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic host_lo = 1'b0;
    wire  data_bus;

    pullup (data_bus);
    assign data_bus = host_lo ? 1'b0 : 1'bz;

    dht11_sensor_emu_if bus_if ();

    dht11_sensor_emu #(
        .START_MIN(P_START), .T_TURN(P_TURN), .T_RESP_LO(P_RLO), .T_RESP_HI(P_RHI),
        .T_BIT_LO(P_BLO), .T_BIT0_HI(P_B0), .T_BIT1_HI(P_B1), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .data(data_bus),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int fd_count = 0;
    bit exp_bus_q[$];
    bit exp_busy_q[$];
    bit exp_fd_q[$];
    bit cap_q[$];
    bit eb, ey, ef;

    // Per-cycle comparison against the model timeline, sampled mid-cycle
    always @(negedge clk) begin
        if (bus_if.frame_done === 1'b1) fd_count++;
        if (exp_bus_q.size() > 0) begin
            eb = exp_bus_q.pop_front();
            ey = exp_busy_q.pop_front();
            ef = exp_fd_q.pop_front();
            cap_q.push_back(data_bus);
            checks += 3;
            if (data_bus !== eb) begin
                errors++;
                $display("FAIL bus t=%0t actual=%b required=%b", $time, data_bus, eb);
            end
            if (bus_if.busy !== ey) begin
                errors++;
                $display("FAIL busy t=%0t actual=%b required=%b", $time, bus_if.busy, ey);
            end
            if (bus_if.frame_done !== ef) begin
                errors++;
                $display("FAIL frame_done t=%0t actual=%b required=%b", $time, bus_if.frame_done, ef);
            end
        end
    end

    task automatic check_eq(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input bit b, input bit y, input bit f);
        exp_bus_q.push_back(b);
        exp_busy_q.push_back(y);
        exp_fd_q.push_back(f);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push_exp(1'b1, 1'b0, 1'b0);
    endtask

    // Wait until every expectation has been compared, bounded by a cycle budget
    task automatic drain(input int limit, input string tag);
        int c;
        c = 0;
        while (exp_bus_q.size() > 0 && c < limit) begin
            @(negedge clk);
            #1;
            c++;
        end
        checks++;
        if (exp_bus_q.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: pending=%0d required=0", tag, exp_bus_q.size());
            exp_bus_q.delete();
            exp_busy_q.delete();
            exp_fd_q.delete();
        end
    endtask

    // Host start pulse of n cycles; the bus is low only because the host drives it
    task automatic host_low(input int n);
        @(posedge clk);
        #1;
        host_lo = 1'b1;
        repeat (n) push_exp(1'b0, 1'b0, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        host_lo = 1'b0;
    endtask

    // Frame model, called on the cycle the host releases the bus. Released
    // high covers two synchronizer stages, the release decision, the
    // turnaround and the registered drive; then the pulse train. busy leads
    // the bus by the one-cycle drive register; frame_done marks the first
    // released cycle after the closing low. stop_bit >= 0 truncates the
    // timeline two cycles into that bit's low.
    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input bit bad, input int stop_bit);
        bit          lev[$];
        int          sum;
        logic [7:0]  cs;
        logic [39:0] word;
        int          last_low;
        int          stop_idx;
        int          n;
        sum  = int'(b0) + int'(b1) + int'(b2) + int'(b3);
        cs   = 8'(sum % 256) ^ (bad ? 8'h01 : 8'h00);
        word = {b0, b1, b2, b3, cs};
        stop_idx = -1;
        repeat (P_TURN + 4) lev.push_back(1'b1);
        repeat (P_RLO) lev.push_back(1'b0);
        repeat (P_RHI) lev.push_back(1'b1);
        for (int k = 39; k >= 0; k--) begin
            if (k == stop_bit) stop_idx = lev.size() + 2;
            repeat (P_BLO) lev.push_back(1'b0);
            repeat (word[k] ? P_B1 : P_B0) lev.push_back(1'b1);
        end
        repeat (P_BLO) lev.push_back(1'b0);
        last_low = lev.size() - 1;
        repeat (3) lev.push_back(1'b1);
        n = (stop_idx >= 0) ? stop_idx + 1 : lev.size();
        for (int i = 0; i < n; i++) begin
            push_exp(lev[i], (i >= 3) && (i < last_low), i == last_low + 1);
        end
    endtask

    // Host-side receiver: split the captured bus into runs and classify bit highs
    task automatic decode_cap(output logic [39:0] word, output int resp_lo, output int resp_hi);
        int lens[$];
        int run;
        bit cur;
        word    = '0;
        resp_lo = 0;
        resp_hi = 0;
        if (cap_q.size() == 0) return;
        cur = cap_q[0];
        run = 0;
        foreach (cap_q[i]) begin
            if (cap_q[i] == cur) begin
                run++;
            end else begin
                lens.push_back(run);
                cur = cap_q[i];
                run = 1;
            end
        end
        lens.push_back(run);
        if (lens.size() < 84) return;
        resp_lo = lens[1];
        resp_hi = lens[2];
        for (int k = 0; k < 40; k++) word[39 - k] = (lens[4 + 2 * k] > 5);
    endtask

    task automatic run_case(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input bit bad,
                            input bit change, input logic [7:0] new_hi, input logic [39:0] req_word);
        logic [39:0] word;
        int          rl, rh, fd0;
        logic [7:0]  rx_sum;
        fd0 = fd_count;
        bus_if.hum_int  = b0;
        bus_if.hum_dec  = b1;
        bus_if.temp_int = b2;
        bus_if.temp_dec = b3;
        bus_if.bad_sum  = bad;
        host_low(30);
        cap_q.delete();
        push_frame(b0, b1, b2, b3, bad, -1);
        if (change) begin
            repeat (80) @(posedge clk);
            #1;
            bus_if.hum_int = new_hi;
        end
        drain(2000, tag);
        decode_cap(word, rl, rh);
        rx_sum = word[39:32] + word[31:24] + word[23:16] + word[15:8];
        check_eq({tag, "_word"}, word, req_word);
        check_eq({tag, "_resp_lo"}, 40'(rl), 40'(P_RLO));
        check_eq({tag, "_resp_hi"}, 40'(rh), 40'(P_RHI));
        check_eq({tag, "_frame_done_count"}, 40'(fd_count - fd0), 40'd1);
        check_eq({tag, "_rx_sum_ok"}, 40'(rx_sum == word[7:0]), 40'(!bad));
        push_idle(6);
        drain(50, {tag, "_tail"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        bus_if.hum_int  = 8'h00;
        bus_if.hum_dec  = 8'h00;
        bus_if.temp_int = 8'h00;
        bus_if.temp_dec = 8'h00;
        bus_if.bad_sum  = 1'b0;

        // Reset state: bus released, no status
        @(posedge clk);
        #1;
        push_idle(3);
        drain(10, "reset");
        check_eq("reset_busy", 40'(bus_if.busy), 40'd0);
        check_eq("reset_frame_done", 40'(bus_if.frame_done), 40'd0);
        rst = 1'b0;
        push_idle(6);
        drain(20, "post_reset");

        // Basic frame
        run_case("basic", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 1'b0, 8'h00, 40'h3700190050);

        // Short host pulse is a glitch: no response, then a proper start works
        host_low(10);
        push_idle(15);
        drain(40, "glitch");
        run_case("after_glitch", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 1'b0, 8'h00, 40'h3700190050);

        // Checksum wraps modulo 256
        run_case("all_ff", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 40'hFFFFFFFFFC);

        // Error injection flips checksum bit 0 only
        run_case("bad_sum", 8'h37, 8'h00, 8'h19, 8'h00, 1'b1, 1'b0, 8'h00, 40'h3700190051);

        // Reset during bit 20: released next cycle, no frame_done, then restart
        fd0 = fd_count;
        bus_if.hum_int  = 8'hA5;
        bus_if.hum_dec  = 8'h5A;
        bus_if.temp_int = 8'h3C;
        bus_if.temp_dec = 8'hC3;
        bus_if.bad_sum  = 1'b0;
        host_low(30);
        push_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b0, 20);
        drain(2000, "pre_reset");
        rst = 1'b1;
        push_idle(4);
        repeat (2) @(posedge clk);
        #1;
        check_eq("midreset_busy", 40'(bus_if.busy), 40'd0);
        rst = 1'b0;
        push_idle(8);
        drain(30, "midreset");
        check_eq("midreset_frame_done_count", 40'(fd_count - fd0), 40'd0);
        run_case("after_reset", 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1'b0, 8'h00, 40'h1234567814);

        // Input change mid-frame does not alter the frame in flight
        run_case("latched", 8'h41, 8'h05, 8'h17, 8'h03, 1'b0, 1'b1, 8'h99, 40'h4105170360);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
